lsu_mem_ctrl: RTL and testbench
===============================

Name: lsu_mem_ctrl

Overview:
Sequential load/store controller between the issue stage and the data RAM. It decodes RV32I load/store instructions and generates the legacy 3-bit mask plus per-byte enables. It drives a single RAM port with a parametrised read latency, then returns the aligned and sign/zero-extended load data through a valid/ready response channel. It replaces the combinational memread/memwrite/mask decode, adding a request/response handshake, store-lane replication and misalignment handling.

Parameters:
ADDR_W, 32, byte-address width; the RAM word address is ADDR_W-2 bits.
TAG_W, 4, width of the request tag returned with the response (issue-slot/ROB id).
RAM_LAT, 1, RAM read latency in cycles, >=1; ram_rdata is valid RAM_LAT cycles after ram_en.

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
req_valid  in  1  request valid
req_ready  out  1  controller can accept a request
req_instr  in  32  full instruction word
req_addr  in  ADDR_W  effective byte address
req_wdata  in  32  store data (rs2)
req_tag  in  TAG_W  request tag
resp_valid  out  1  response valid
resp_ready  in  1  consumer accepts the response
resp_rdata  out  32  formatted load data; 0 for stores and faults
resp_tag  out  TAG_W  tag of the completed request
resp_is_load  out  1  completed request was a load
resp_err  out  1  instruction was not a legal load/store
resp_misalign  out  1  misaligned access (see Optional Feature)
ram_en  out  1  one-cycle RAM access strobe
ram_we  out  1  write enable, qualified by ram_en
ram_addr  out  ADDR_W-2  word address req_addr[ADDR_W-1:2]
ram_be  out  4  byte enables
ram_mask  out  3  legacy mask code
ram_wdata  out  32  lane-replicated store data
ram_rdata  in  32  RAM read data

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: state=IDLE. All outputs are 0 except ram_mask=3'b111. req_ready is 1 from the first cycle after reset.
- Legal opcode/funct3 combinations:
  - Opcode 0000011: lb 000, lh 001, lw 010, lbu 100, lhu 101.
  - Opcode 0100011: sb 000, sh 001, sw 010.
  - Anything else is illegal.
- ram_mask codes: lw/sw 110, lb/sb 100, lbu 000, lh/sh 101, lhu 001, otherwise 111.
- The request is latched on req_valid & req_ready. req_ready=1 only in IDLE.
- FSM states: IDLE, ACCESS, WAIT, RESP.
  - IDLE -> ACCESS on accept of a legal, aligned request.
  - IDLE -> RESP directly on accept of an illegal or trapped-misaligned request. There is no RAM access; resp_valid comes the next cycle.
  - ACCESS: ram_en=1 for exactly this cycle; ram_we=1 for stores. Store -> RESP; load -> WAIT with counter=RAM_LAT.
  - WAIT: the counter decrements each cycle. In the cycle it reads 1, ram_rdata is captured, formatted into resp_rdata, and the FSM goes to RESP.
  - RESP: resp_valid=1 and all resp_* outputs are held stable. RESP -> IDLE on resp_ready.
- Latency from the accept edge to the first resp_valid cycle:
  - Store: 2 cycles.
  - Load: RAM_LAT+2 cycles.
  - Fault: 1 cycle.
- Sustained throughput is one request per RAM_LAT+3 cycles (loads) with resp_ready=1.
- Byte enables, where a = addr[1:0]:
  - Byte access: ram_be = 4'b0001 << a.
  - Half access: ram_be = 4'b0011 << {addr[1],1'b0}.
  - Word access: ram_be = 4'b1111.
  - Loads drive the same pattern.
- ram_wdata: sb replicates wdata[7:0] to all 4 lanes; sh replicates wdata[15:0] to both halves; sw passes wdata through.
- Load formatting: select lane byte/half from ram_rdata by address.
  - lb/lh sign-extend to 32 bits.
  - lbu/lhu zero-extend.
  - lw passes the word through.
- ram_addr, ram_be, ram_mask and ram_wdata are held from accept until the next accept; they are don't-care when ram_en=0.
- Reset mid-operation returns the FSM to IDLE; no response is emitted for the in-flight request. A store already strobed is not undone.
- resp_err and resp_misalign are never both 1; illegal decode takes priority.

Optional Feature:
LSU_MISALIGN_TRAP_EN.
- Defined: a half access with addr[0]=1 or a word access with addr[1:0]!=0 is not sent to RAM. resp_misalign=1 and resp_rdata=0, with 1-cycle fault latency.
- Undefined: resp_misalign is tied to 0. Low address bits are silently masked: half uses {addr[1],1'b0} and word uses 2'b00. The access proceeds normally.

Test Plan:
- sb: addr 0x103, wdata 0x000000AB -> ACCESS cycle has ram_en=1, ram_we=1, ram_addr=0x40, ram_be=4'b1000, ram_wdata=0xABABABAB, ram_mask=3'b100; resp_valid 2 cycles after accept with resp_rdata=0.
- lb/lbu: addr 0x102, ram_rdata=0x12803456, RAM_LAT=1 -> lb gives resp_rdata=0xFFFFFF80 and lbu gives 0x00000080, resp_valid 3 cycles after accept, resp_tag echoed.
- Latency: RAM_LAT=3, lw addr 0x200, ram_rdata=0xDEADBEEF -> resp_valid exactly 5 cycles after accept, resp_rdata=0xDEADBEEF, ram_en high for one cycle only.
- Misaligned lh: addr 0x101 -> with LSU_MISALIGN_TRAP_EN, no ram_en and resp_misalign=1 one cycle later; without it, ram_be=4'b0011 and the data is formatted from bytes 0-1.
- Illegal/backpressure: instr 0x00000033 (add) -> resp_err=1 one cycle after accept, no ram_en. Hold resp_ready=0 for 3 cycles -> resp_valid and data stay stable and req_ready=0; IDLE follows the cycle after resp_ready=1.
- Reset mid-load: assert rst in WAIT -> next cycle state is IDLE, resp_valid=0, req_ready=1; a following lw completes normally.

Source files
------------

// File: rtl/lsu_mem_ctrl.sv
// RV32I load/store controller: decodes lb/lh/lw/lbu/lhu/sb/sh/sw, drives one RAM port, returns formatted load data.
// Define LSU_MISALIGN_TRAP_EN to fault misaligned half/word accesses instead of silently masking the low address bits.
module lsu_mem_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int TAG_W   = 4,
    parameter int RAM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [31:0]       req_instr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [TAG_W-1:0]  req_tag,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic [TAG_W-1:0]  resp_tag,
    output logic              resp_is_load,
    output logic              resp_err,
    output logic              resp_misalign,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-3:0] ram_addr,
    output logic [3:0]        ram_be,
    output logic [2:0]        ram_mask,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);
    localparam int CNT_W = $clog2(RAM_LAT + 1);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [2:0]         lat_f3;
    logic [1:0]         lat_a;
    logic               lat_load;
    logic [TAG_W-1:0]   lat_tag;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [1:0]  a;
    logic        is_load;
    logic        is_store;
    logic        legal;
    logic        misalign;
    logic [2:0]  mask;
    logic [3:0]  be;
    logic [31:0] wdata_rep;
    logic        unused_instr;

    assign opcode       = req_instr[6:0];
    assign funct3       = req_instr[14:12];
    assign a            = req_addr[1:0];
    assign unused_instr = ^{req_instr[31:15], req_instr[11:7]};

    always_comb begin
        is_load   = (opcode == 7'b0000011) &&
                    (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        is_store  = (opcode == 7'b0100011) &&
                    (funct3 inside {3'b000, 3'b001, 3'b010});
        legal     = is_load || is_store;
        mask      = 3'b111;
        be        = 4'b0000;
        wdata_rep = req_wdata;
        if (legal) begin
            case (funct3)
                3'b000:  mask = 3'b100;
                3'b001:  mask = 3'b101;
                3'b010:  mask = 3'b110;
                3'b100:  mask = 3'b000;
                3'b101:  mask = 3'b001;
                default: mask = 3'b111;
            endcase
            case (funct3[1:0])
                2'b00: begin
                    be        = 4'b0001 << a;
                    wdata_rep = {4{req_wdata[7:0]}};
                end
                2'b01: begin
                    be        = 4'b0011 << {a[1], 1'b0};
                    wdata_rep = {2{req_wdata[15:0]}};
                end
                default: be = 4'b1111;
            endcase
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign = legal && (((funct3[1:0] == 2'b01) && a[0]) ||
                                ((funct3[1:0] == 2'b10) && (a != 2'b00)));
`else
    assign misalign = 1'b0;
`endif

    // Lane selection uses only the bits the access size can legally address.
    logic [31:0] byte_sh;
    logic [31:0] half_sh;
    logic [31:0] ld_data;

    always_comb begin
        byte_sh = ram_rdata >> {lat_a, 3'b000};
        half_sh = ram_rdata >> {lat_a[1], 4'b0000};
        case (lat_f3)
            3'b000:  ld_data = {{24{byte_sh[7]}}, byte_sh[7:0]};
            3'b001:  ld_data = {{16{half_sh[15]}}, half_sh[15:0]};
            3'b100:  ld_data = {24'h000000, byte_sh[7:0]};
            3'b101:  ld_data = {16'h0000, half_sh[15:0]};
            default: ld_data = ram_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            lat_f3        <= '0;
            lat_a         <= '0;
            lat_load      <= 1'b0;
            lat_tag       <= '0;
            req_ready     <= 1'b0;
            resp_valid    <= 1'b0;
            resp_rdata    <= '0;
            resp_tag      <= '0;
            resp_is_load  <= 1'b0;
            resp_err      <= 1'b0;
            resp_misalign <= 1'b0;
            ram_en        <= 1'b0;
            ram_we        <= 1'b0;
            ram_addr      <= '0;
            ram_be        <= '0;
            ram_mask      <= 3'b111;
            ram_wdata     <= '0;
        end else begin
            ram_en <= 1'b0;
            ram_we <= 1'b0;
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        ram_addr  <= req_addr[ADDR_W-1:2];
                        ram_be    <= be;
                        ram_mask  <= mask;
                        ram_wdata <= wdata_rep;
                        lat_f3    <= funct3;
                        lat_a     <= a;
                        lat_load  <= is_load;
                        lat_tag   <= req_tag;
                        // Faults skip the RAM entirely and answer on the next cycle.
                        if (!legal || misalign) begin
                            state         <= RESP;
                            resp_valid    <= 1'b1;
                            resp_rdata    <= '0;
                            resp_tag      <= req_tag;
                            resp_is_load  <= is_load;
                            resp_err      <= !legal;
                            resp_misalign <= misalign;
                        end else begin
                            state  <= ACCESS;
                            ram_en <= 1'b1;
                            ram_we <= is_store;
                        end
                    end
                end
                ACCESS: begin
                    if (lat_load) begin
                        state <= WAIT;
                        cnt   <= CNT_W'(RAM_LAT);
                    end else begin
                        state         <= RESP;
                        resp_valid    <= 1'b1;
                        resp_rdata    <= '0;
                        resp_tag      <= lat_tag;
                        resp_is_load  <= 1'b0;
                        resp_err      <= 1'b0;
                        resp_misalign <= 1'b0;
                    end
                end
                WAIT: begin
                    if (cnt == CNT_W'(1)) begin
                        state         <= RESP;
                        resp_valid    <= 1'b1;
                        resp_rdata    <= ld_data;
                        resp_tag      <= lat_tag;
                        resp_is_load  <= 1'b1;
                        resp_err      <= 1'b0;
                        resp_misalign <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Scoreboard bench for lsu_mem_ctrl: expected responses are queued at issue and checked when resp_valid appears.
// Builds with or without LSU_MISALIGN_TRAP_EN; the misaligned-access expectations follow the macro.
module tb_lsu_mem_ctrl;
    localparam int ADDR_W  = 32;
    localparam int TAG_W   = 4;
    localparam int RAM_LAT = 3;
    localparam int LS = 2;
    localparam int LL = RAM_LAT + 2;
    localparam int LF = 1;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;

    logic              clk;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic [31:0]       req_instr;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic [TAG_W-1:0]  req_tag;
    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_rdata;
    logic [TAG_W-1:0]  resp_tag;
    logic              resp_is_load;
    logic              resp_err;
    logic              resp_misalign;
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-3:0] ram_addr;
    logic [3:0]        ram_be;
    logic [2:0]        ram_mask;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;

    lsu_mem_ctrl #(.ADDR_W(ADDR_W), .TAG_W(TAG_W), .RAM_LAT(RAM_LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_instr(req_instr),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_tag(req_tag),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_tag(resp_tag), .resp_is_load(resp_is_load), .resp_err(resp_err),
        .resp_misalign(resp_misalign),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_be(ram_be),
        .ram_mask(ram_mask), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    // RAM model: byte-enabled writes, reads delivered RAM_LAT cycles after the strobe.
    logic [31:0] mem [0:255];
    logic [31:0] rd_pipe [0:RAM_LAT-1];
    always @(posedge clk) begin
        if (ram_en && ram_we)
            for (int b = 0; b < 4; b++)
                if (ram_be[b]) mem[ram_addr[7:0]][8*b +: 8] <= ram_wdata[8*b +: 8];
        rd_pipe[0] <= (ram_en && !ram_we) ? mem[ram_addr[7:0]] : 32'h5A5A_0BAD;
        for (int i = 1; i < RAM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign ram_rdata = rd_pipe[RAM_LAT-1];

    typedef struct {
        logic [3:0]  tag;
        logic [31:0] rdata;
        logic        is_load;
        logic        err;
        logic        mis;
        int          lat;
        int          accept;
    } exp_t;

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [1:0]  off;
        logic [31:0] wd;
        logic [2:0]  mask;
        logic [3:0]  be;
        logic [31:0] wdrep;
        logic [31:0] data;
    } vec_t;

    exp_t exp_q[$];
    exp_t cur;
    logic in_resp = 1'b0;
    int   en_count = 0;
    int   n_checks = 0;
    int   n_fails  = 0;
    logic [3:0] tag_n = 4'd1;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fails++;
            $display("[TB] FAIL %s: actual=0x%08h expected=0x%08h", tag, actual, expected);
        end
    endtask

    function automatic logic [31:0] mkInstr(input logic [6:0] op, input logic [2:0] f3);
        return {7'h00, 5'd2, 5'd1, f3, 5'd3, op};
    endfunction

    function automatic exp_t mkExp(input logic [3:0] tag, input logic [31:0] rdata,
                                   input logic ld, input logic er, input logic ms, input int lat);
        exp_t e;
        e.tag = tag; e.rdata = rdata; e.is_load = ld; e.err = er; e.mis = ms;
        e.lat = lat; e.accept = 0;
        return e;
    endfunction

    // Returns #1 after the accept edge, i.e. inside the ACCESS (or fault RESP) cycle.
    task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] addr,
                                 input logic [31:0] wdata, input exp_t e);
        int guard = 0;
        @(posedge clk); #1;
        while (!req_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 100) checkOutput("req_ready_timeout", {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_instr = instr;
        req_addr  = addr;
        req_wdata = wdata;
        req_tag   = e.tag;
        e.accept  = cycle + 1;
        exp_q.push_back(e);
        @(posedge clk); #1;
        req_valid = 1'b0;
        tag_n = tag_n + 4'd1;
    endtask

    task automatic waitIdle();
        int guard = 0;
        while ((exp_q.size() != 0 || !req_ready) && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 100) checkOutput("idle_timeout", {30'b0, exp_q.size() != 0, req_ready}, 32'd1);
    endtask

    always @(negedge clk) begin
        if (ram_en) en_count++;
        if (resp_valid) begin
            if (!in_resp) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_resp", {31'b0, resp_valid}, 32'd0);
                end else begin
                    cur = exp_q.pop_front();
                    in_resp = 1'b1;
                    checkOutput("latency", 32'(cycle - cur.accept + 1), 32'(cur.lat));
                end
            end
            if (in_resp) begin
                checkOutput("resp_tag", {28'b0, resp_tag}, {28'b0, cur.tag});
                checkOutput("resp_rdata", resp_rdata, cur.rdata);
                checkOutput("resp_is_load", {31'b0, resp_is_load}, {31'b0, cur.is_load});
                checkOutput("resp_err", {31'b0, resp_err}, {31'b0, cur.err});
                checkOutput("resp_misalign", {31'b0, resp_misalign}, {31'b0, cur.mis});
                if (resp_ready) in_resp = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    vec_t vecs[6];
    int   en_before;

    initial begin
        vecs[0] = '{OP_LD, 3'b000, 2'd1, 32'h0, 3'b100, 4'b0010, 32'h0, 32'hFFFF_FFC3};
        vecs[1] = '{OP_LD, 3'b100, 2'd3, 32'h0, 3'b000, 4'b1000, 32'h0, 32'h0000_00A1};
        vecs[2] = '{OP_LD, 3'b001, 2'd2, 32'h0, 3'b101, 4'b1100, 32'h0, 32'hFFFF_A1B2};
        vecs[3] = '{OP_LD, 3'b101, 2'd0, 32'h0, 3'b001, 4'b0011, 32'h0, 32'h0000_C3D4};
        vecs[4] = '{OP_LD, 3'b010, 2'd0, 32'h0, 3'b110, 4'b1111, 32'h0, 32'hA1B2_C3D4};
        vecs[5] = '{OP_ST, 3'b001, 2'd2, 32'h0000_5A6B, 3'b101, 4'b1100, 32'h5A6B_5A6B, 32'h0};

        rst = 1'b1; req_valid = 1'b0; req_instr = '0; req_addr = '0;
        req_wdata = '0; req_tag = '0; resp_ready = 1'b1;

        @(posedge clk); #1;
        checkOutput("rst_req_ready", {31'b0, req_ready}, 32'd0);
        checkOutput("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        checkOutput("rst_ram_en", {31'b0, ram_en}, 32'd0);
        checkOutput("rst_ram_mask", {29'b0, ram_mask}, 32'd7);
        checkOutput("rst_resp_rdata", resp_rdata, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        checkOutput("post_rst_req_ready", {31'b0, req_ready}, 32'd1);

        $display("[TB] sw then sb lane replication");
        applyStimulus(mkInstr(OP_ST, 3'b010), 32'h100, 32'h1280_3456, mkExp(tag_n, 32'h0, 1'b0, 1'b0, 1'b0, LS));
        waitIdle();
        applyStimulus(mkInstr(OP_ST, 3'b000), 32'h103, 32'h0000_00AB, mkExp(tag_n, 32'h0, 1'b0, 1'b0, 1'b0, LS));
        checkOutput("sb_ram_en", {31'b0, ram_en}, 32'd1);
        checkOutput("sb_ram_we", {31'b0, ram_we}, 32'd1);
        checkOutput("sb_ram_addr", 32'(ram_addr), 32'h40);
        checkOutput("sb_ram_be", {28'b0, ram_be}, 32'b1000);
        checkOutput("sb_ram_wdata", ram_wdata, 32'hABAB_ABAB);
        checkOutput("sb_ram_mask", {29'b0, ram_mask}, 32'b100);
        @(posedge clk); #1;
        checkOutput("sb_ram_en_drop", {31'b0, ram_en}, 32'd0);
        waitIdle();

        $display("[TB] lb / lbu sign handling");
        applyStimulus(mkInstr(OP_LD, 3'b000), 32'h102, 32'h0, mkExp(tag_n, 32'hFFFF_FF80, 1'b1, 1'b0, 1'b0, LL));
        waitIdle();
        applyStimulus(mkInstr(OP_LD, 3'b100), 32'h102, 32'h0, mkExp(tag_n, 32'h0000_0080, 1'b1, 1'b0, 1'b0, LL));
        waitIdle();

        $display("[TB] lw latency and single strobe");
        applyStimulus(mkInstr(OP_ST, 3'b010), 32'h200, 32'hDEAD_BEEF, mkExp(tag_n, 32'h0, 1'b0, 1'b0, 1'b0, LS));
        waitIdle();
        en_before = en_count;
        applyStimulus(mkInstr(OP_LD, 3'b010), 32'h200, 32'h0, mkExp(tag_n, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, LL));
        waitIdle();
        checkOutput("lw_en_pulses", 32'(en_count - en_before), 32'd1);

        $display("[TB] mask/be/format table");
        applyStimulus(mkInstr(OP_ST, 3'b010), 32'h300, 32'hA1B2_C3D4, mkExp(tag_n, 32'h0, 1'b0, 1'b0, 1'b0, LS));
        waitIdle();
        for (int i = 0; i < 6; i++) begin
            logic st;
            st = (vecs[i].op == OP_ST);
            applyStimulus(mkInstr(vecs[i].op, vecs[i].f3), 32'h300 | {30'b0, vecs[i].off}, vecs[i].wd,
                          mkExp(tag_n, vecs[i].data, !st, 1'b0, 1'b0, st ? LS : LL));
            checkOutput("tbl_ram_mask", {29'b0, ram_mask}, {29'b0, vecs[i].mask});
            checkOutput("tbl_ram_be", {28'b0, ram_be}, {28'b0, vecs[i].be});
            checkOutput("tbl_ram_we", {31'b0, ram_we}, {31'b0, st});
            checkOutput("tbl_ram_addr", 32'(ram_addr), 32'hC0);
            if (st) checkOutput("tbl_ram_wdata", ram_wdata, vecs[i].wdrep);
            waitIdle();
        end
        applyStimulus(mkInstr(OP_LD, 3'b010), 32'h300, 32'h0, mkExp(tag_n, 32'h5A6B_C3D4, 1'b1, 1'b0, 1'b0, LL));
        waitIdle();

        $display("[TB] misaligned half and word");
        en_before = en_count;
`ifdef LSU_MISALIGN_TRAP_EN
        applyStimulus(mkInstr(OP_LD, 3'b001), 32'h101, 32'h0, mkExp(tag_n, 32'h0, 1'b1, 1'b0, 1'b1, LF));
        checkOutput("mis_lh_ram_en", {31'b0, ram_en}, 32'd0);
        waitIdle();
        applyStimulus(mkInstr(OP_LD, 3'b010), 32'h202, 32'h0, mkExp(tag_n, 32'h0, 1'b1, 1'b0, 1'b1, LF));
        waitIdle();
        checkOutput("mis_en_pulses", 32'(en_count - en_before), 32'd0);
`else
        applyStimulus(mkInstr(OP_LD, 3'b001), 32'h101, 32'h0, mkExp(tag_n, 32'h0000_3456, 1'b1, 1'b0, 1'b0, LL));
        checkOutput("mis_lh_ram_be", {28'b0, ram_be}, 32'b0011);
        waitIdle();
        applyStimulus(mkInstr(OP_LD, 3'b010), 32'h202, 32'h0, mkExp(tag_n, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, LL));
        checkOutput("mis_lw_ram_be", {28'b0, ram_be}, 32'b1111);
        waitIdle();
        checkOutput("mis_en_pulses", 32'(en_count - en_before), 32'd2);
`endif

        $display("[TB] illegal instruction with backpressure");
        en_before = en_count;
        resp_ready = 1'b0;
        applyStimulus(32'h0000_0033, 32'h100, 32'h0, mkExp(tag_n, 32'h0, 1'b0, 1'b1, 1'b0, LF));
        checkOutput("ill_ram_en", {31'b0, ram_en}, 32'd0);
        checkOutput("ill_ram_mask", {29'b0, ram_mask}, 32'b111);
        for (int i = 0; i < 3; i++) begin
            checkOutput("stall_resp_valid", {31'b0, resp_valid}, 32'd1);
            checkOutput("stall_req_ready", {31'b0, req_ready}, 32'd0);
            @(posedge clk); #1;
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        checkOutput("release_resp_valid", {31'b0, resp_valid}, 32'd0);
        checkOutput("release_req_ready", {31'b0, req_ready}, 32'd1);
        applyStimulus(mkInstr(OP_ST, 3'b011), 32'h100, 32'h0, mkExp(tag_n, 32'h0, 1'b0, 1'b1, 1'b0, LF));
        waitIdle();
        applyStimulus(mkInstr(OP_LD, 3'b110), 32'h101, 32'h0, mkExp(tag_n, 32'h0, 1'b0, 1'b1, 1'b0, LF));
        waitIdle();
        checkOutput("ill_en_pulses", 32'(en_count - en_before), 32'd0);

        $display("[TB] reset during WAIT");
        applyStimulus(mkInstr(OP_LD, 3'b010), 32'h200, 32'h0, mkExp(tag_n, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, LL));
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        void'(exp_q.pop_back());
        checkOutput("midrst_resp_valid", {31'b0, resp_valid}, 32'd0);
        checkOutput("midrst_ram_en", {31'b0, ram_en}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        checkOutput("midrst_req_ready", {31'b0, req_ready}, 32'd1);
        for (int i = 0; i < RAM_LAT + 2; i++) begin
            @(posedge clk); #1;
        end
        checkOutput("midrst_no_resp", {31'b0, resp_valid}, 32'd0);
        applyStimulus(mkInstr(OP_LD, 3'b010), 32'h200, 32'h0, mkExp(tag_n, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, LL));
        waitIdle();

        repeat (3) @(posedge clk);
        #1;
        checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
